// File: rtl/video_regseq.sv
// Register-access sequencer for a video register bank. It filters the raw bus strobes, decodes the
// latched address, and emits start/end pulses plus a shared phase toggle for paired registers.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// IDLE     | no access in progress; waiting for a filtered strobe rise
// WRITE    | write access open; address and data latched
// READ     | read access open; address latched
// CONFLICT | both strobes seen high together; wait for both to drop
module video_regseq #(
    parameter int                               P_addr_width  = 3,
    parameter int                               P_filter      = 1,
    parameter logic [(2**P_addr_width)-1:0]     P_toggle_mask = 8'b0110_0000,
    parameter int                               P_clear_reg   = 2
) (
    input  logic                             I_clock,
    input  logic                             I_reset,
    input  logic [P_addr_width-1:0]          I_addr,
    input  logic [7:0]                       I_data,
    input  logic                             I_wren,
    input  logic                             I_rden,
    output logic [(2**P_addr_width)-1:0]     O_reg,
    output logic [7:0]                       O_data,
    output logic [(2**P_addr_width)-1:0]     O_reg_wrstb,
    output logic [(2**P_addr_width)-1:0]     O_reg_rdstb,
    output logic [(2**P_addr_width)-1:0]     O_reg_wrend,
    output logic [(2**P_addr_width)-1:0]     O_reg_rdend,
    output logic                             O_phase,
    output logic                             O_busy,
    output logic                             O_conflict
);

    localparam int                        P_regs  = 2**P_addr_width;
    localparam logic [P_regs-1:0]         L_one   = P_regs'(1);
    localparam logic [P_addr_width-1:0]   L_clear = P_addr_width'(P_clear_reg);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WRITE    = 2'd1,
        ST_READ     = 2'd2,
        ST_CONFLICT = 2'd3
    } state_t;

    state_t                 state_q, state_d;
    logic [P_filter-1:0]    wr_hist_q, wr_hist_d;
    logic [P_filter-1:0]    rd_hist_q, rd_hist_d;
    logic [P_filter:0]      wr_ext, rd_ext;
    logic                   wr_filt_q, wr_filt_d;
    logic                   rd_filt_q, rd_filt_d;
    logic                   wr_dly_q, rd_dly_q;
    logic [P_addr_width-1:0] addr_q, addr_d;
    logic [7:0]             data_q, data_d;
    logic [P_regs-1:0]      wrstb_q, wrstb_d;
    logic [P_regs-1:0]      rdstb_q, rdstb_d;
    logic [P_regs-1:0]      wrend_q, wrend_d;
    logic [P_regs-1:0]      rdend_q, rdend_d;
    logic                   phase_q, phase_d;
    logic                   conflict_q, conflict_d;
    logic                   wr_rise, rd_rise;

    // Level filter: the new sample is included, so the level moves on the P_filter-th agreeing sample.
    always_comb begin
        wr_ext    = {wr_hist_q, I_wren};
        rd_ext    = {rd_hist_q, I_rden};
        wr_hist_d = wr_ext[P_filter-1:0];
        rd_hist_d = rd_ext[P_filter-1:0];
        wr_filt_d = wr_filt_q;
        rd_filt_d = rd_filt_q;
        if (&wr_hist_d) begin
            wr_filt_d = 1'b1;
        end else if (~|wr_hist_d) begin
            wr_filt_d = 1'b0;
        end
        if (&rd_hist_d) begin
            rd_filt_d = 1'b1;
        end else if (~|rd_hist_d) begin
            rd_filt_d = 1'b0;
        end
    end

    assign wr_rise = wr_filt_q & ~wr_dly_q;
    assign rd_rise = rd_filt_q & ~rd_dly_q;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wrstb_d    = '0;
        rdstb_d    = '0;
        wrend_d    = '0;
        rdend_d    = '0;
        phase_d    = phase_q;
        conflict_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (wr_filt_q && rd_filt_q) begin
                    state_d    = ST_CONFLICT;
                    conflict_d = 1'b1;
                end else if (wr_rise && !rd_filt_q) begin
                    state_d = ST_WRITE;
                    addr_d  = I_addr;
                    data_d  = I_data;
                    wrstb_d = L_one << I_addr;
                end else if (rd_rise && !wr_filt_q) begin
                    state_d = ST_READ;
                    addr_d  = I_addr;
                    rdstb_d = L_one << I_addr;
                end
            end
            ST_WRITE: begin
                if (!wr_filt_q) begin
                    state_d = ST_IDLE;
                    wrend_d = L_one << addr_q;
                    if (P_toggle_mask[addr_q]) begin
                        phase_d = ~phase_q;
                    end
                end
            end
            ST_READ: begin
                if (!rd_filt_q) begin
                    state_d = ST_IDLE;
                    rdend_d = L_one << addr_q;
                    if (addr_q == L_clear) begin
                        phase_d = 1'b0;
                    end
                end
            end
            ST_CONFLICT: begin
                if (!wr_filt_q && !rd_filt_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge I_clock) begin
        if (I_reset) begin
            state_q    <= ST_IDLE;
            wr_hist_q  <= '0;
            rd_hist_q  <= '0;
            wr_filt_q  <= 1'b0;
            rd_filt_q  <= 1'b0;
            wr_dly_q   <= 1'b0;
            rd_dly_q   <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            wrstb_q    <= '0;
            rdstb_q    <= '0;
            wrend_q    <= '0;
            rdend_q    <= '0;
            phase_q    <= 1'b0;
            conflict_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_hist_q  <= wr_hist_d;
            rd_hist_q  <= rd_hist_d;
            wr_filt_q  <= wr_filt_d;
            rd_filt_q  <= rd_filt_d;
            wr_dly_q   <= wr_filt_q;
            rd_dly_q   <= rd_filt_q;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wrstb_q    <= wrstb_d;
            rdstb_q    <= rdstb_d;
            wrend_q    <= wrend_d;
            rdend_q    <= rdend_d;
            phase_q    <= phase_d;
            conflict_q <= conflict_d;
        end
    end

    // Decode is only shown while an access is open; the latched address itself persists.
    assign O_reg       = (state_q == ST_WRITE || state_q == ST_READ) ? (L_one << addr_q) : '0;
    assign O_data      = data_q;
    assign O_reg_wrstb = wrstb_q;
    assign O_reg_rdstb = rdstb_q;
    assign O_reg_wrend = wrend_q;
    assign O_reg_rdend = rdend_q;
    assign O_phase     = phase_q;
    assign O_busy      = (state_q != ST_IDLE);
    assign O_conflict  = conflict_q;

endmodule

// File: tb/tb_video_regseq.sv
// Bench for video_regseq: directed access scenarios plus random strobe traffic, all checked
// against an access-level reference model that works from raw sample windows.
module tb_video_regseq;

    localparam int         F      = 2;
    localparam logic [7:0] TOGGLE = 8'b0110_0000;
    localparam int         CLR    = 2;

    logic       clk = 1'b0;
    logic       rst, wren, rden;
    logic [2:0] addr;
    logic [7:0] data;
    logic [7:0] o_reg, o_data, o_wrstb, o_rdstb, o_wrend, o_rdend;
    logic       o_phase, o_busy, o_conflict;

    int total = 0;
    int bad   = 0;

    video_regseq #(
        .P_addr_width (3),
        .P_filter     (F),
        .P_toggle_mask(TOGGLE),
        .P_clear_reg  (CLR)
    ) dut (
        .I_clock    (clk),
        .I_reset    (rst),
        .I_addr     (addr),
        .I_data     (data),
        .I_wren     (wren),
        .I_rden     (rden),
        .O_reg      (o_reg),
        .O_data     (o_data),
        .O_reg_wrstb(o_wrstb),
        .O_reg_rdstb(o_rdstb),
        .O_reg_wrend(o_wrend),
        .O_reg_rdend(o_rdend),
        .O_phase    (o_phase),
        .O_busy     (o_busy),
        .O_conflict (o_conflict)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: mode 0 idle, 1 write, 2 read, 3 conflict.
    bit         wwin[F];
    bit         rwin[F];
    bit         m_wf, m_rf, m_wf_old, m_rf_old;
    int         m_mode;
    int         m_addr;
    logic [7:0] m_data;
    bit         m_phase;
    logic [7:0] e_wrstb, e_rdstb, e_wrend, e_rdend;
    bit         e_conf;

    int         n_wrstb, n_rdstb, n_wrend, n_rdend, n_conf, busy_seen;
    logic [7:0] last_wrend;

    function automatic logic [7:0] bitpos(input int a);
        logic [7:0] v;
        v = 8'(1 << a);
        return v;
    endfunction

    function automatic bit window_level(input int ones, input bit held);
        if (ones == F) return 1'b1;
        if (ones == 0) return 1'b0;
        return held;
    endfunction

    task automatic model_edge(input bit r, input bit w, input bit rd, input int a, input logic [7:0] d);
        int wsum, rsum;
        e_wrstb = '0; e_rdstb = '0; e_wrend = '0; e_rdend = '0; e_conf = 1'b0;
        if (r) begin
            for (int i = 0; i < F; i++) begin
                wwin[i] = 1'b0;
                rwin[i] = 1'b0;
            end
            m_wf = 0; m_rf = 0; m_wf_old = 0; m_rf_old = 0;
            m_mode = 0; m_addr = 0; m_data = '0; m_phase = 1'b0;
            return;
        end
        case (m_mode)
            0: begin
                if (m_wf && m_rf) begin
                    m_mode = 3; e_conf = 1'b1;
                end else if (m_wf && !m_wf_old && !m_rf) begin
                    m_mode = 1; m_addr = a; m_data = d; e_wrstb = bitpos(a);
                end else if (m_rf && !m_rf_old && !m_wf) begin
                    m_mode = 2; m_addr = a; e_rdstb = bitpos(a);
                end
            end
            1: if (!m_wf) begin
                m_mode = 0; e_wrend = bitpos(m_addr);
                if (TOGGLE[m_addr]) m_phase = !m_phase;
            end
            2: if (!m_rf) begin
                m_mode = 0; e_rdend = bitpos(m_addr);
                if (m_addr == CLR) m_phase = 1'b0;
            end
            default: if (!m_wf && !m_rf) m_mode = 0;
        endcase
        for (int i = F - 1; i > 0; i--) begin
            wwin[i] = wwin[i-1];
            rwin[i] = rwin[i-1];
        end
        wwin[0] = w;
        rwin[0] = rd;
        wsum = 0; rsum = 0;
        for (int i = 0; i < F; i++) begin
            wsum += int'(wwin[i]);
            rsum += int'(rwin[i]);
        end
        m_wf_old = m_wf;
        m_rf_old = m_rf;
        m_wf = window_level(wsum, m_wf);
        m_rf = window_level(rsum, m_rf);
    endtask

    task automatic clr_cnt();
        n_wrstb = 0; n_rdstb = 0; n_wrend = 0; n_rdend = 0; n_conf = 0; busy_seen = 0;
        last_wrend = '0;
    endtask

    task automatic step(input bit r, input bit w, input bit rd, input logic [2:0] a, input logic [7:0] d);
        logic [7:0] e_reg;
        rst = r; wren = w; rden = rd; addr = a; data = d;
        @(posedge clk);
        #1;
        model_edge(r, w, rd, int'(a), d);
        e_reg = (m_mode == 1 || m_mode == 2) ? bitpos(m_addr) : 8'h00;
        chk("o_reg",      32'(o_reg),      32'(e_reg));
        chk("o_data",     32'(o_data),     32'(m_data));
        chk("o_wrstb",    32'(o_wrstb),    32'(e_wrstb));
        chk("o_rdstb",    32'(o_rdstb),    32'(e_rdstb));
        chk("o_wrend",    32'(o_wrend),    32'(e_wrend));
        chk("o_rdend",    32'(o_rdend),    32'(e_rdend));
        chk("o_phase",    32'(o_phase),    32'(m_phase));
        chk("o_busy",     32'(o_busy),     32'(m_mode != 0));
        chk("o_conflict", 32'(o_conflict), 32'(e_conf));
        if (o_wrstb != 0) n_wrstb++;
        if (o_rdstb != 0) n_rdstb++;
        if (o_wrend != 0) begin n_wrend++; last_wrend = o_wrend; end
        if (o_rdend != 0) n_rdend++;
        if (o_conflict)   n_conf++;
        if (o_busy)       busy_seen = 1;
    endtask

    task automatic access(input bit is_wr, input logic [2:0] a, input logic [7:0] d, input int hold);
        repeat (hold) step(1'b0, is_wr, !is_wr, a, d);
        repeat (F + 2) step(1'b0, 1'b0, 1'b0, a, d);
    endtask

    initial begin
        bit         w_lv, r_lv;
        clr_cnt();
        step(1, 0, 0, 3'd0, 8'h00);
        step(1, 1, 1, 3'd7, 8'hFF);
        chk("rst_busy",  32'(o_busy),  32'd0);
        chk("rst_reg",   32'(o_reg),   32'd0);
        chk("rst_phase", 32'(o_phase), 32'd0);

        // Write reg 5 with A7, strobe high for six samples.
        step(0, 1, 0, 3'd5, 8'hA7);
        step(0, 1, 0, 3'd5, 8'hA7);
        chk("wrstb_early", 32'(o_wrstb), 32'h00);
        step(0, 1, 0, 3'd5, 8'hA7);
        chk("wrstb_a", 32'(o_wrstb), 32'h20);
        chk("data_a",  32'(o_data),  32'hA7);
        chk("reg_a",   32'(o_reg),   32'h20);
        step(0, 1, 0, 3'd5, 8'hA7);
        chk("wrstb_once", 32'(o_wrstb), 32'h00);
        step(0, 1, 0, 3'd5, 8'hA7);
        step(0, 1, 0, 3'd5, 8'hA7);
        step(0, 0, 0, 3'd5, 8'hA7);
        step(0, 0, 0, 3'd5, 8'hA7);
        chk("wrend_early", 32'(o_wrend), 32'h00);
        step(0, 0, 0, 3'd5, 8'hA7);
        chk("wrend_a", 32'(o_wrend), 32'h20);
        chk("phase_a", 32'(o_phase), 32'd1);
        step(0, 0, 0, 3'd5, 8'hA7);

        // Paired-register phase behaviour.
        step(1, 0, 0, 3'd0, 8'h00);
        access(1, 3'd6, 8'h11, 4); chk("ph_w6_1", 32'(o_phase), 32'd1);
        access(1, 3'd6, 8'h22, 4); chk("ph_w6_2", 32'(o_phase), 32'd0);
        access(1, 3'd5, 8'h33, 3); chk("ph_w5",   32'(o_phase), 32'd1);
        access(0, 3'd2, 8'h00, 4); chk("ph_rd2",  32'(o_phase), 32'd0);
        access(1, 3'd6, 8'h44, 4); chk("ph_w6_3", 32'(o_phase), 32'd1);
        access(0, 3'd3, 8'h00, 4); chk("ph_rd3",  32'(o_phase), 32'd1);
        access(1, 3'd1, 8'h55, 4); chk("ph_w1",   32'(o_phase), 32'd1);

        // Single-sample glitches on each strobe.
        clr_cnt();
        step(0, 1, 0, 3'd4, 8'h66);
        repeat (3) step(0, 0, 0, 3'd4, 8'h66);
        step(0, 0, 1, 3'd4, 8'h66);
        repeat (3) step(0, 0, 0, 3'd4, 8'h66);
        chk("glitch_busy",  32'(busy_seen), 32'd0);
        chk("glitch_wrstb", 32'(n_wrstb),   32'd0);
        chk("glitch_rdstb", 32'(n_rdstb),   32'd0);

        // Both strobes rise together.
        clr_cnt();
        repeat (4) step(0, 1, 1, 3'd2, 8'h77);
        repeat (2) step(0, 0, 1, 3'd2, 8'h77);
        chk("conf_busy_hold", 32'(o_busy), 32'd1);
        repeat (3) step(0, 0, 0, 3'd2, 8'h77);
        chk("conf_busy_end", 32'(o_busy),  32'd0);
        chk("conf_pulses",   32'(n_conf),  32'd1);
        chk("conf_wrstb",    32'(n_wrstb), 32'd0);
        chk("conf_rdstb",    32'(n_rdstb), 32'd0);

        // Read strobe and address change inside a write.
        clr_cnt();
        repeat (3) step(0, 1, 0, 3'd1, 8'h88);
        repeat (4) step(0, 1, 1, 3'd7, 8'h99);
        chk("ovl_reg",  32'(o_reg),  32'h02);
        chk("ovl_data", 32'(o_data), 32'h88);
        repeat (3) step(0, 0, 1, 3'd7, 8'h99);
        repeat (3) step(0, 0, 0, 3'd7, 8'h99);
        chk("ovl_wrend_n",   32'(n_wrend),    32'd1);
        chk("ovl_wrend_reg", 32'(last_wrend), 32'h02);
        chk("ovl_rdstb",     32'(n_rdstb),    32'd0);

        // Reset in the middle of a read with the strobe held.
        clr_cnt();
        repeat (4) step(0, 0, 1, 3'd4, 8'h00);
        step(1, 0, 1, 3'd4, 8'h00);
        chk("rrst_busy", 32'(o_busy), 32'd0);
        step(0, 0, 1, 3'd4, 8'h00);
        chk("rrst_rdstb1", 32'(o_rdstb), 32'h00);
        step(0, 0, 1, 3'd4, 8'h00);
        chk("rrst_rdstb2", 32'(o_rdstb), 32'h00);
        step(0, 0, 1, 3'd4, 8'h00);
        chk("rrst_rdstb3", 32'(o_rdstb), 32'h10);
        repeat (4) step(0, 0, 0, 3'd4, 8'h00);
        chk("rrst_rdend", 32'(n_rdend), 32'd1);
        chk("rrst_rdstb", 32'(n_rdstb), 32'd2);

        // Random traffic with persistent levels, glitches, overlaps and rare resets.
        w_lv = 0; r_lv = 0;
        for (int k = 0; k < 2500; k++) begin
            if ($urandom_range(0, 3) == 0) w_lv = !w_lv;
            if ($urandom_range(0, 3) == 0) r_lv = !r_lv;
            step($urandom_range(0, 79) == 0, w_lv, r_lv, 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
